i2c_random_read: RTL and testbench

I2C master that performs a single-byte random read from a 24Cxx-class EEPROM: START, device address + W, word address, repeated START, device address + R, one data byte, master NACK, STOP.
It is the read-side companion to the existing EEPROM write master and shares the same bus pins via open-drain drive.
A host pulses start with a word address and receives rdata plus a done pulse and an ack_err flag.

---
 rtl/i2c_random_read.sv | 168 ++++++++++++++++
 tb/tb_i2c_random_read.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_random_read.sv
// Open-drain I2C master performing one random read from a 24Cxx EEPROM:
// START, dev+W, word address, repeated START, dev+R, one byte, NACK, STOP.
module i2c_random_read #(
    parameter int         CLK_DIV  = 4,
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       CLOCK,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] addr,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output wire        I2C_SCLK,
    inout  wire        I2C_SDAT
);

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEVW,
        S_ACK1,
        S_WADDR,
        S_ACK2,
        S_RSTART,
        S_DEVR,
        S_ACK3,
        S_READ,
        S_MNACK,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic [9:0] r_div;
    logic [7:0] r_addr;
    logic [7:0] r_rx;
    logic       r_sclLow;
    logic       r_sdaLow;

    state_t     w_nextState;
    logic [1:0] w_nextQ;
    logic [2:0] w_nextBit;
    logic [1:0] w_drive;
    logic       w_tick;
    logic       w_sample;
    logic       w_sdaIn;

    assign I2C_SCLK = r_sclLow ? 1'b0 : 1'bz;
    assign I2C_SDAT = r_sdaLow ? 1'b0 : 1'bz;
    assign w_sdaIn  = I2C_SDAT;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_sample = busy && (r_q == 2'd2) && (r_div == 10'd0);

    // Line levels {sclLow, sdaLow} for a given state, quarter and bit index.
    function automatic logic [1:0] lineDrive(input state_t st, input logic [1:0] q,
                                             input logic [2:0] b, input logic [7:0] wordAddr);
        logic [7:0] txByte;
        logic       sclLow;
        sclLow = (q == 2'd0) || (q == 2'd3);
        case (st)
            S_DEVW:  txByte = {DEV_ADDR, 1'b0};
            S_DEVR:  txByte = {DEV_ADDR, 1'b1};
            default: txByte = wordAddr;
        endcase
        case (st)
            S_START:                    lineDrive = {q == 2'd3, q[1]};
            S_RSTART:                   lineDrive = {sclLow, q[1]};
            S_STOP:                     lineDrive = {q == 2'd0, ~q[1]};
            S_DEVW, S_WADDR, S_DEVR:    lineDrive = {sclLow, ~txByte[3'd7 - b]};
            S_ACK1, S_ACK2, S_ACK3,
            S_READ, S_MNACK:            lineDrive = {sclLow, 1'b0};
            default:                    lineDrive = 2'b00;
        endcase
    endfunction

    // Sequencing at each quarter boundary; a failed ACK diverts to STOP after its bit.
    always_comb begin
        w_nextState = r_state;
        w_nextQ     = r_q + 2'd1;
        w_nextBit   = r_bit;
        if (r_q == 2'd3) begin
            case (r_state)
                S_START:  w_nextState = S_DEVW;
                S_DEVW:   w_nextState = (r_bit == 3'd7) ? S_ACK1 : S_DEVW;
                S_ACK1:   w_nextState = ack_err ? S_STOP : S_WADDR;
                S_WADDR:  w_nextState = (r_bit == 3'd7) ? S_ACK2 : S_WADDR;
                S_ACK2:   w_nextState = ack_err ? S_STOP : S_RSTART;
                S_RSTART: w_nextState = S_DEVR;
                S_DEVR:   w_nextState = (r_bit == 3'd7) ? S_ACK3 : S_DEVR;
                S_ACK3:   w_nextState = ack_err ? S_STOP : S_READ;
                S_READ:   w_nextState = (r_bit == 3'd7) ? S_MNACK : S_READ;
                S_MNACK:  w_nextState = S_STOP;
                S_STOP:   w_nextState = S_IDLE;
                default:  w_nextState = S_IDLE;
            endcase
            if (r_state inside {S_DEVW, S_WADDR, S_DEVR, S_READ}) begin
                w_nextBit = r_bit + 3'd1;
            end
        end
    end

    assign w_drive = lineDrive(w_nextState, w_nextQ, w_nextBit, r_addr);

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_div    <= 10'd0;
            r_addr   <= 8'h00;
            r_rx     <= 8'h00;
            r_sclLow <= 1'b0;
            r_sdaLow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    ack_err  <= 1'b0;
                    r_addr   <= addr;
                    r_state  <= S_START;
                    r_q      <= 2'd0;
                    r_bit    <= 3'd0;
                    r_div    <= 10'd0;
                    r_sclLow <= 1'b0;
                    r_sdaLow <= 1'b0;
                end
            end else begin
                if (w_sample) begin
                    if ((r_state inside {S_ACK1, S_ACK2, S_ACK3}) && w_sdaIn) begin
                        ack_err <= 1'b1;
                    end
                    if (r_state == S_READ) begin
                        r_rx <= {r_rx[6:0], w_sdaIn};
                    end
                end
                if (w_tick) begin
                    r_div    <= 10'd0;
                    r_state  <= w_nextState;
                    r_q      <= w_nextQ;
                    r_bit    <= w_nextBit;
                    r_sclLow <= w_drive[1];
                    r_sdaLow <= w_drive[0];
                    if (r_state == S_MNACK && r_q == 2'd3) begin
                        rdata <= r_rx;
                    end
                    if (w_nextState == S_IDLE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end else begin
                    r_div <= r_div + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_random_read.sv
// Directed bench for i2c_random_read: two masters (CLK_DIV 4 and 1) share one
// pulled-up bus with a behavioural 24Cxx slave model.
module tb_i2c_random_read;

    logic       CLOCK = 1'b0;
    logic       reset_n = 1'b0;
    logic       start4, start1;
    logic [7:0] addr4, addr1;
    logic       busy4, busy1, done4, done1, ackErr4, ackErr1;
    logic [7:0] rdata4, rdata1;
    wire        sclBus;
    wire        sdaBus;

    int vectorsApplied = 0;
    int miscompares = 0;

    always #5 CLOCK = ~CLOCK;

    pullup (sclBus);
    pullup (sdaBus);

    i2c_random_read #(.CLK_DIV(4), .DEV_ADDR(7'h50)) dut4 (
        .CLOCK(CLOCK), .reset_n(reset_n), .start(start4), .addr(addr4),
        .busy(busy4), .done(done4), .ack_err(ackErr4), .rdata(rdata4),
        .I2C_SCLK(sclBus), .I2C_SDAT(sdaBus)
    );

    i2c_random_read #(.CLK_DIV(1), .DEV_ADDR(7'h50)) dut1 (
        .CLOCK(CLOCK), .reset_n(reset_n), .start(start1), .addr(addr1),
        .busy(busy1), .done(done1), .ack_err(ackErr1), .rdata(rdata1),
        .I2C_SCLK(sclBus), .I2C_SDAT(sdaBus)
    );

    // Slave model state
    logic       slaveSdaLow = 1'b0;
    logic       slavePresent;
    logic [7:0] mem [256];
    logic [7:0] rxLog [$];
    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    int         sMode = 0;
    int         sBits = 0;
    int         sByteIdx = 0;
    int         sTxBits = 0;
    int         sTxClk = 0;
    logic [7:0] sShift = 8'h00;
    logic [7:0] sWord = 8'h00;
    logic [7:0] sTx = 8'h00;
    logic       sAddrOk = 1'b0;
    logic       sIsRead = 1'b0;
    int         nackCnt = 0;

    assign sdaBus = slaveSdaLow ? 1'b0 : 1'bz;

    // EEPROM behaviour: bytes captured on SCL rise, ACK/data driven after SCL fall.
    always @(sclBus or sdaBus or reset_n) begin
        if (reset_n !== 1'b1) begin
            sMode = 0;
            sBits = 0;
            slaveSdaLow = 1'b0;
        end else if (sclBus !== prevScl) begin
            if (sclBus === 1'b1) begin
                if (sMode == 1 && sBits < 8) begin
                    sShift = {sShift[6:0], sdaBus};
                    sBits++;
                end else if (sMode == 2) begin
                    sTxClk++;
                    if (sTxClk == 9 && sdaBus === 1'b1) nackCnt++;
                end
            end else begin
                if (sMode == 1 && sBits == 8) begin
                    rxLog.push_back(sShift);
                    if (sByteIdx == 0) begin
                        sAddrOk = slavePresent && (sShift[7:1] == 7'h50);
                        sIsRead = sShift[0];
                    end else if (sByteIdx == 1 && !sIsRead) begin
                        sWord = sShift;
                    end
                    slaveSdaLow = sAddrOk;
                    sByteIdx++;
                    sBits = 9;
                end else if (sMode == 1 && sBits == 9) begin
                    slaveSdaLow = 1'b0;
                    sBits = 0;
                    if (sAddrOk && sIsRead) begin
                        sMode = 2;
                        sTx = mem[sWord];
                        slaveSdaLow = !sTx[7];
                        sTxBits = 1;
                        sTxClk = 0;
                    end
                end else if (sMode == 2) begin
                    if (sTxBits < 8) begin
                        slaveSdaLow = !sTx[3'(7 - sTxBits)];
                        sTxBits++;
                    end else begin
                        slaveSdaLow = 1'b0;
                    end
                end
            end
        end else if (sdaBus !== prevSda && sclBus === 1'b1) begin
            if (sdaBus === 1'b0) begin
                sMode = 1;
                sBits = 0;
                sByteIdx = 0;
                sAddrOk = 1'b0;
                sIsRead = 1'b0;
            end else begin
                sMode = 0;
                slaveSdaLow = 1'b0;
            end
        end
        prevScl = sclBus;
        prevSda = sdaBus;
    end

    // SDA edges while SCL is high are START/RSTART (fall) or STOP (rise).
    int fallsHigh = 0;
    int risesHigh = 0;
    always @(sdaBus) begin
        if (reset_n === 1'b1 && sclBus === 1'b1) begin
            if (sdaBus === 1'b0) fallsHigh++;
            else if (sdaBus === 1'b1) risesHigh++;
        end
    end

    int busyCnt4 = 0, busyCnt1 = 0, doneCnt4 = 0, doneCnt1 = 0;
    always @(negedge CLOCK) begin
        if (busy4 === 1'b1) busyCnt4++;
        if (busy1 === 1'b1) busyCnt1++;
        if (done4 === 1'b1) doneCnt4++;
        if (done1 === 1'b1) doneCnt1++;
    end

    int baseBusy4, baseBusy1, baseDone4, baseDone1, baseLog, baseNack, baseFalls, baseRises;

    task automatic markBase();
        baseBusy4 = busyCnt4;
        baseBusy1 = busyCnt1;
        baseDone4 = doneCnt4;
        baseDone1 = doneCnt1;
        baseLog   = rxLog.size();
        baseNack  = nackCnt;
        baseFalls = fallsHigh;
        baseRises = risesHigh;
    endtask

    function automatic logic [7:0] logAt(input int idx);
        logAt = 8'hxx;
        if (idx < rxLog.size()) logAt = rxLog[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
            $error("[TB] %s miscompared", tag);
        end
    endtask

    task automatic applyStimulus(input bit useFast, input logic [7:0] wordAddr);
        @(negedge CLOCK);
        if (useFast) begin
            start1 = 1'b1;
            addr1  = wordAddr;
        end else begin
            start4 = 1'b1;
            addr4  = wordAddr;
        end
        @(negedge CLOCK);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic waitDone(input bit useFast, input int maxCycles);
        bit   seen;
        logic busyAt;
        seen   = 1'b0;
        busyAt = 1'b1;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge CLOCK);
            if ((useFast ? done1 : done4) === 1'b1) begin
                seen   = 1'b1;
                busyAt = useFast ? busy1 : busy4;
            end
        end
        checkOutput("doneSeen", 32'(seen), 1);
        checkOutput("busyLowAtDone", 32'(busyAt), 0);
        repeat (4) @(negedge CLOCK);
    endtask

    initial begin
        start4 = 1'b0; addr4 = 8'h00;
        start1 = 1'b0; addr1 = 8'h00;
        slavePresent = 1'b1;
        foreach (mem[i]) mem[i] = 8'hFF;
        mem[8'h00] = 8'h87;
        mem[8'h3C] = 8'h5A;
        mem[8'hC3] = 8'h96;
        $display("[TB] i2c_random_read directed run");

        repeat (3) @(negedge CLOCK);
        checkOutput("rstBusy", 32'(busy4), 0);
        checkOutput("rstDone", 32'(done4), 0);
        checkOutput("rstAckErr", 32'(ackErr4), 0);
        checkOutput("rstRdata", 32'(rdata4), 8'h00);
        checkOutput("rstScl", 32'(sclBus), 1);
        checkOutput("rstSda", 32'(sdaBus), 1);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK);

        // Basic read of 0x87 at 0x00
        markBase();
        applyStimulus(1'b0, 8'h00);
        waitDone(1'b0, 2000);
        checkOutput("t1Rdata", 32'(rdata4), 8'h87);
        checkOutput("t1AckErr", 32'(ackErr4), 0);
        checkOutput("t1BusyCycles", 32'(busyCnt4 - baseBusy4), 624);
        checkOutput("t1DonePulses", 32'(doneCnt4 - baseDone4), 1);
        checkOutput("t1ByteCount", 32'(rxLog.size() - baseLog), 3);
        checkOutput("t1Byte0", 32'(logAt(baseLog)), 8'hA0);
        checkOutput("t1Byte1", 32'(logAt(baseLog + 1)), 8'h00);
        checkOutput("t1Byte2", 32'(logAt(baseLog + 2)), 8'hA1);
        checkOutput("t1MasterNack", 32'(nackCnt - baseNack), 1);
        checkOutput("t1SdaFallsSclHigh", 32'(fallsHigh - baseFalls), 2);
        checkOutput("t1SdaRisesSclHigh", 32'(risesHigh - baseRises), 1);

        // Read 0x5A at 0x3C
        markBase();
        applyStimulus(1'b0, 8'h3C);
        waitDone(1'b0, 2000);
        checkOutput("t2Rdata", 32'(rdata4), 8'h5A);
        checkOutput("t2AckErr", 32'(ackErr4), 0);
        checkOutput("t2Byte0", 32'(logAt(baseLog)), 8'hA0);
        checkOutput("t2Byte1", 32'(logAt(baseLog + 1)), 8'h3C);
        checkOutput("t2Byte2", 32'(logAt(baseLog + 2)), 8'hA1);
        checkOutput("t2MasterNack", 32'(nackCnt - baseNack), 1);
        checkOutput("t2Stop", 32'(risesHigh - baseRises), 1);

        // Absent slave: ACK1 fails, then STOP straight away
        slavePresent = 1'b0;
        markBase();
        applyStimulus(1'b0, 8'h11);
        repeat (152) @(negedge CLOCK);
        checkOutput("t3AckErrBeforeSample", 32'(ackErr4), 0);
        @(negedge CLOCK);
        checkOutput("t3AckErrAfterSample", 32'(ackErr4), 1);
        checkOutput("t3BusyDuringStop", 32'(busy4), 1);
        waitDone(1'b0, 2000);
        checkOutput("t3AckErrHeld", 32'(ackErr4), 1);
        checkOutput("t3RdataHeld", 32'(rdata4), 8'h5A);
        checkOutput("t3BusyCycles", 32'(busyCnt4 - baseBusy4), 176);
        checkOutput("t3DonePulses", 32'(doneCnt4 - baseDone4), 1);
        checkOutput("t3ByteCount", 32'(rxLog.size() - baseLog), 1);
        checkOutput("t3Stop", 32'(risesHigh - baseRises), 1);
        slavePresent = 1'b1;

        // Second start while busy is ignored
        markBase();
        applyStimulus(1'b0, 8'hC3);
        checkOutput("t4AckErrCleared", 32'(ackErr4), 0);
        repeat (100) @(negedge CLOCK);
        start4 = 1'b1;
        addr4  = 8'h00;
        @(negedge CLOCK);
        start4 = 1'b0;
        waitDone(1'b0, 2000);
        repeat (20) @(negedge CLOCK);
        checkOutput("t4Rdata", 32'(rdata4), 8'h96);
        checkOutput("t4Byte1", 32'(logAt(baseLog + 1)), 8'hC3);
        checkOutput("t4BusyCycles", 32'(busyCnt4 - baseBusy4), 624);
        checkOutput("t4DonePulses", 32'(doneCnt4 - baseDone4), 1);
        checkOutput("t4IdleAfter", 32'(busy4), 0);

        // Reset in the middle of READ
        applyStimulus(1'b0, 8'h3C);
        repeat (500) @(negedge CLOCK);
        reset_n = 1'b0;
        #1;
        checkOutput("t5Scl", 32'(sclBus), 1);
        checkOutput("t5Sda", 32'(sdaBus), 1);
        checkOutput("t5Busy", 32'(busy4), 0);
        checkOutput("t5Rdata", 32'(rdata4), 8'h00);
        checkOutput("t5AckErr", 32'(ackErr4), 0);
        repeat (3) @(negedge CLOCK);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK);
        markBase();
        applyStimulus(1'b0, 8'h00);
        waitDone(1'b0, 2000);
        checkOutput("t5ReadAfterReset", 32'(rdata4), 8'h87);
        checkOutput("t5AckErrAfter", 32'(ackErr4), 0);

        // CLK_DIV=1 back-to-back reads
        markBase();
        applyStimulus(1'b1, 8'h3C);
        waitDone(1'b1, 1000);
        checkOutput("t6aRdata", 32'(rdata1), 8'h5A);
        checkOutput("t6aAckErr", 32'(ackErr1), 0);
        checkOutput("t6aBusyCycles", 32'(busyCnt1 - baseBusy1), 156);
        checkOutput("t6aDonePulses", 32'(doneCnt1 - baseDone1), 1);
        checkOutput("t6aSdaFallsSclHigh", 32'(fallsHigh - baseFalls), 2);
        checkOutput("t6aSdaRisesSclHigh", 32'(risesHigh - baseRises), 1);
        markBase();
        applyStimulus(1'b1, 8'hC3);
        waitDone(1'b1, 1000);
        checkOutput("t6bRdata", 32'(rdata1), 8'h96);
        checkOutput("t6bBusyCycles", 32'(busyCnt1 - baseBusy1), 156);
        checkOutput("t6bByte1", 32'(logAt(baseLog + 1)), 8'hC3);
        checkOutput("t6bMasterNack", 32'(nackCnt - baseNack), 1);
        checkOutput("t6bSdaFallsSclHigh", 32'(fallsHigh - baseFalls), 2);
        checkOutput("t6bSdaRisesSclHigh", 32'(risesHigh - baseRises), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
